// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The full result is computed on the launch edge and parked in pending
// registers. A down-counter then holds busy high for a fixed latency and
// commits the result to hi/lo on its final edge. mthi/mtlo are single-cycle
// writes that are accepted only while the unit is idle.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [4:0] MULT_LOAD = MULT_CYCLES[4:0];
  localparam logic [4:0] DIV_LOAD  = DIV_CYCLES[4:0];

  logic        busy_r;
  logic [4:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] pend_hi_r;
  logic [31:0] pend_lo_r;
  logic        pend_valid_r;

  logic        launch_s;
  logic        mthi_s;
  logic        mtlo_s;
  logic [4:0]  load_cnt_s;

  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        div_zero_s;
  logic [31:0] divisor_s;
  logic [31:0] uquot_s;
  logic [31:0] urem_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] prod_s;

  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;
  logic        res_valid_s;
  logic        last_cycle_s;

  // Decode start/mdu_op into launch, mthi and mtlo strobes; nothing is accepted while busy.
  always_comb begin
    launch_s   = 1'b0;
    mthi_s     = 1'b0;
    mtlo_s     = 1'b0;
    load_cnt_s = 5'd0;
    if (start && !busy_r) begin
      case (mdu_op)
        OP_MULT, OP_MULTU: begin
          launch_s   = 1'b1;
          load_cnt_s = MULT_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          launch_s   = 1'b1;
          load_cnt_s = DIV_LOAD;
        end
        OP_MTHI: mthi_s = 1'b1;
        OP_MTLO: mtlo_s = 1'b1;
        OP_NONE: launch_s = 1'b0;
        default: launch_s = 1'b0;
      endcase
    end else begin
      launch_s = 1'b0;
    end
  end

  // Division on magnitudes avoids the signed -2^31 / -1 trap; signs are reapplied afterwards.
  always_comb begin
    a_neg_s    = (mdu_op == OP_DIV) && A[31];
    b_neg_s    = (mdu_op == OP_DIV) && B[31];
    a_mag_s    = a_neg_s ? (32'd0 - A) : A;
    b_mag_s    = b_neg_s ? (32'd0 - B) : B;
    div_zero_s = (B == 32'd0);
    divisor_s  = div_zero_s ? 32'd1 : b_mag_s;
    uquot_s    = a_mag_s / divisor_s;
    urem_s     = a_mag_s % divisor_s;
    quot_s     = (a_neg_s ^ b_neg_s) ? (32'd0 - uquot_s) : uquot_s;
    rem_s      = a_neg_s ? (32'd0 - urem_s) : urem_s;
  end

  // Sign- or zero-extend to 64 bits so one multiplier serves both mult and multu.
  always_comb begin
    a_ext_s = (mdu_op == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
    b_ext_s = (mdu_op == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
    prod_s  = a_ext_s * b_ext_s;
  end

  // Select the result to park; a divide by zero runs its full latency but never commits.
  always_comb begin
    res_hi_s    = 32'd0;
    res_lo_s    = 32'd0;
    res_valid_s = 1'b0;
    case (mdu_op)
      OP_MULT, OP_MULTU: begin
        res_hi_s    = prod_s[63:32];
        res_lo_s    = prod_s[31:0];
        res_valid_s = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi_s    = rem_s;
        res_lo_s    = quot_s;
        res_valid_s = !div_zero_s;
      end
      default: res_valid_s = 1'b0;
    endcase
  end

  assign last_cycle_s = busy_r && (cnt_r == 5'd1);

  // Busy flag and latency counter: load on launch, count down, drop on the final edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      cnt_r  <= 5'd0;
    end else if (launch_s) begin
      busy_r <= 1'b1;
      cnt_r  <= load_cnt_s;
    end else if (last_cycle_s) begin
      busy_r <= 1'b0;
      cnt_r  <= 5'd0;
    end else if (busy_r) begin
      cnt_r  <= cnt_r - 5'd1;
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  // Pending result captured from the launch-edge operands; invalidated once consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi_r    <= 32'd0;
      pend_lo_r    <= 32'd0;
      pend_valid_r <= 1'b0;
    end else if (launch_s) begin
      pend_hi_r    <= res_hi_s;
      pend_lo_r    <= res_lo_s;
      pend_valid_r <= res_valid_s;
    end else if (last_cycle_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // HI register: commit at end of operation, or direct write by mthi while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 32'd0;
    end else if (last_cycle_s && pend_valid_r) begin
      hi_r <= pend_hi_r;
    end else if (mthi_s) begin
      hi_r <= A;
    end else begin
      hi_r <= hi_r;
    end
  end

  // LO register: commit at end of operation, or direct write by mtlo while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_r <= 32'd0;
    end else if (last_cycle_s && pend_valid_r) begin
      lo_r <= pend_lo_r;
    end else if (mtlo_s) begin
      lo_r <= A;
    end else begin
      lo_r <= lo_r;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed test-plan cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MULT_CYCLES;
    if (op == 3'd3 || op == 3'd4) return DIV_CYCLES;
    return 0;
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endfunction

  // Called at a negedge: counts consecutive busy samples, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    launch(op, a, b);
    model_apply(op, a, b);
    wait_idle(cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles(op)));
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    int cyc;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // Test plan 1-3
    run_op("mult_neg", 3'd1, 32'hFFFFFFFF, 32'h00000002);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h00000002);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'h00000002);
    run_op("divu", 3'd4, 32'h00000007, 32'h00000002);

    // Test plan 4: divide by zero leaves preloaded values, then overflow case
    run_op("mthi", 3'd5, 32'h00000011, 32'd0);
    run_op("mtlo", 3'd6, 32'h00000022, 32'd0);
    run_op("div0", 3'd3, 32'h12345678, 32'd0);
    check("div0_hi_const", hi, 32'h00000011);
    check("div0_lo_const", lo, 32'h00000022);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo_const", lo, 32'h80000000);

    // Test plan 5: mtlo and a second mult during busy are ignored
    launch(3'd1, 32'd3, 32'd4);
    model_apply(3'd1, 32'd3, 32'd4);
    check("t5_busy1", {31'd0, busy}, 32'd1);
    start = 1'b1; mdu_op = 3'd6; A = 32'h55;
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd1; A = 32'd7; B = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle(cyc);
    check("t5_remaining", 32'(cyc), 32'd3);
    check("t5_hi", hi, 32'd0);
    check("t5_lo", lo, 32'd12);
    repeat (12) @(negedge clk);
    check("t5_no_relaunch", {31'd0, busy}, 32'd0);
    check("t5_lo_after", lo, 32'd12);

    // Test plan 6: reset mid-divide aborts it
    launch(3'd4, 32'd100, 32'd7);
    check("t6_busy1", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_hi", hi, 32'd0);
    check("t6_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("t6_late_hi", hi, 32'd0);
    check("t6_late_lo", lo, 32'd0);

    // Reset wins over start on the same edge
    run_op("pre_mthi", 3'd5, 32'hABCD0000, 32'd0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mdu_op = 3'd1; A = 32'd3; B = 32'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("rst_start_hi", hi, 32'd0);
    check("rst_start_lo", lo, 32'd0);

    // Randomized operations
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom % 6)
        0: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        1: b = 32'd0;
        2: begin a = $urandom % 64; b = $urandom % 16; end
        3: b = -($urandom % 8);
        default: ;
      endcase
      run_op("rand", op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the execute stage beside the ALU and takes the same RD1/RD2 operands.
- Serves mult, multu, div, divu, mthi and mtlo; hi/lo outputs feed the register-write mux for mfhi/mflo.
- Exposes busy so the hazard/stall logic can freeze dependent HI/LO instructions.

Parameters:
- MULT_CYCLES, 5: busy duration for mult/multu (allowed range 1–31).
- DIV_CYCLES, 10: busy duration for div/divu (allowed range 1–31).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; launches the operation in mdu_op.
- mdu_op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved.
- A  input  32  operand A (rs value).
- B  input  32  operand B (rt value).
- busy  output  1  high while an operation is in flight.
- hi  output  32  HI register, registered.
- lo  output  32  LO register, registered.

Behaviour:
- Reset (synchronous, active-high)
  - hi=0, lo=0, busy=0, cycle counter=0, pending result cleared.
  - An in-flight operation is aborted and never commits.
  - Reset wins over start on the same edge.
- Launch
  - Launch condition: start=1 with mdu_op in {001,010,011,100} and busy=0.
  - On that edge: result computed from the current A/B and stored in pending regs; counter loaded with MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
  - A and B are sampled only on the launch edge; later changes have no effect.
- Count
  - While busy=1 the counter decrements each edge.
  - On the edge where the counter is 1: hi/lo take the pending result, busy->0, counter->0.
  - Net timing: launch at edge E0; busy=1 for exactly N cycles; new hi/lo and busy=0 are both visible after edge E0+N.
- Start while busy
  - Ignored entirely; the running operation is unaffected.
  - The hazard unit must treat (start | busy) as busy; the mdu does not stall anything itself.
- mthi / mtlo
  - Condition: start=1, mdu_op=101 or 110, busy=0.
  - The selected register takes A at that edge (single-cycle write); the other register is unchanged; busy stays 0.
  - Ignored while busy=1.
- Ignored opcodes
  - mdu_op=000 or 111 with start=1: no effect.
  - start=0: mdu_op is don't-care.
- Arithmetic
  - mult: signed 32x32 -> 64-bit product; hi = product[63:32], lo = product[31:0].
  - multu: same, unsigned.
  - div: signed; lo = quotient truncated toward zero; hi = remainder, sign of dividend (A).
  - divu: unsigned; lo = quotient, hi = remainder.
  - Divide by zero (B=0): the operation runs the full DIV_CYCLES with busy asserted, then hi/lo are left unchanged.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Outputs
  - hi and lo are register outputs with no combinational path from A/B.
  - During busy they hold their old values.

Test Plan:
1. mult, A=0xFFFFFFFF, B=0x00000002 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
2. multu, same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
3. Signed division:
   - div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - divu A=7, B=2 -> lo=3, hi=1.
4. Divide by zero and overflow:
   - hi=0x11, lo=0x22 preloaded via mthi/mtlo; div with B=0 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
   - div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Ignored writes during busy:
   - mult 3*4 launched; mtlo A=0x55 and a second mult start issued at cycles 2 and 3 of busy.
   - Expected: both ignored; busy falls exactly 5 cycles after the first launch; hi=0, lo=12.
6. Reset mid-operation: div launched, reset asserted at busy cycle 4 -> next cycle busy=0, hi=0, lo=0; no commit in later cycles.
